uart_tx_param: RTL and testbench

// - Parametrised UART transmitter: data width, parity, stop bits and runtime baud divisor, fronted by a small FIFO.
// - Accepts bytes on a valid/ready stream and serialises them LSB-first onto tx.
// - Sits between the host/register block and the serial pin; replaces the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo.sv | 50 +++++
 rtl/uart_tx_param.sv | 122 ++++++++++++
 tb/tb_uart_tx_param.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, FSM state encoding and parity helpers shared by UART blocks
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction
  function automatic logic parity_bit(input logic [1:0] mode, input logic xor_all);
    return (mode == PAR_ODD) ? ~xor_all : xor_all;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with full/empty/level, simultaneous push and pop honoured
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;
  assign full    = level_q == LW'(DEPTH);
  assign empty   = level_q == '0;
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // next pointers and occupancy
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
  end
  // pointer and level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  // storage needs no reset; level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-fronted UART transmitter with runtime divisor, parity and stop-bit options
module uart_tx_param import uart_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic [1:0]                      parity_mode,
  input  logic                            two_stop,
  input  logic                            s_valid,
  input  logic [DATA_W-1:0]               s_data,
  output logic                            s_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);
  uart_state_e       state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d, fifo_rdata;
  logic [1:0]        mode_q, mode_d;
  logic              par_q, par_d, two_q, two_d, tx_q, tx_d;
  logic              fifo_full, fifo_empty, push, pop, bit_end, frame_done;
  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign bit_end    = cnt_q == div_q - DIV_W'(1);
  assign frame_done = (state_q == ST_STOP) && bit_end && (!two_q || idx_q != '0);
  assign pop        = ((state_q == ST_IDLE) || frame_done) && !fifo_empty;
  uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
  // frame sequencing: bit timing, shifting, parity and stop handling; a pop always starts a new frame
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == ST_IDLE) ? cnt_q : (bit_end ? '0 : cnt_q + DIV_W'(1));
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    mode_d  = mode_q;
    par_d   = par_q;
    two_d   = two_q;
    tx_d    = tx_q;
    case (state_q)
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        idx_d   = '0;
        tx_d    = sh_q[0];
      end
      ST_DATA: if (bit_end) begin
        if (idx_q == LAST) begin
          state_d = has_parity(mode_q) ? ST_PARITY : ST_STOP;
          tx_d    = has_parity(mode_q) ? par_q : 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d = ST_STOP;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
      ST_STOP: if (frame_done) begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end else if (bit_end) begin
        idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
    if (pop) begin
      state_d = ST_START;
      cnt_d   = '0;
      div_d   = (baud_div == '0) ? DIV_W'(1) : baud_div;
      sh_d    = fifo_rdata;
      mode_d  = parity_mode;
      par_d   = parity_bit(parity_mode, ^fifo_rdata);
      two_d   = two_stop;
      tx_d    = 1'b0;
    end
  end
  // FSM and datapath registers; reset aborts any frame and idles the line high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(1);
      idx_q   <= '0;
      sh_q    <= '0;
      mode_q  <= PAR_NONE;
      par_q   <= 1'b0;
      two_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      two_q   <= two_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for 8-bit and 7-bit transmitter instances
module tb_uart_tx_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic        s_valid8 = 1'b0, s_valid7 = 1'b0;
  logic [7:0]  s_data8 = '0;
  logic [6:0]  s_data7 = '0;
  logic        s_ready8, s_ready7, tx8, tx7, busy8, busy7;
  logic [2:0]  level8, level7;
  int checks = 0;
  int errors = 0;
  typedef struct {int data; int w; int div; int mode; int two;} exp_t;
  exp_t q[$];

  uart_tx_param #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) u8 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .s_valid(s_valid8), .s_data(s_data8), .s_ready(s_ready8), .tx(tx8), .busy(busy8), .fifo_level(level8));
  uart_tx_param #(.DATA_W(7), .DIV_W(16), .FIFO_DEPTH(4)) u7 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .s_valid(s_valid7), .s_data(s_data7), .s_ready(s_ready7), .tx(tx7), .busy(busy7), .fifo_level(level7));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int txs(input bit sel);
    return sel ? int'(tx7) : int'(tx8);
  endfunction

  task automatic push(input bit sel, input int d, input bit acc, input int dv, input int md, input int tw);
    check("s_ready", sel ? int'(s_ready7) : int'(s_ready8), int'(acc));
    if (acc) q.push_back('{d, sel ? 7 : 8, (dv == 0) ? 1 : dv, md, tw});
    if (sel) begin s_valid7 = 1'b1; s_data7 = d[6:0]; end
    else begin s_valid8 = 1'b1; s_data8 = d[7:0]; end
    tick;
    s_valid7 = 1'b0;
    s_valid8 = 1'b0;
  endtask

  task automatic recv(input bit sel, input bit imm);
    exp_t e;
    int bits[16];
    int nb = 0;
    int t = 0;
    int par = 0;
    if (imm) check("b2b_start", txs(sel), 0);
    while (txs(sel) != 0 && t < 2000) begin tick; t++; end
    if (t >= 2000) begin check("start_timeout", t, 0); return; end
    if (q.size() == 0) begin check("sb_empty", 0, 1); return; end
    e = q.pop_front();
    bits[nb++] = 0;
    for (int i = 0; i < e.w; i++) begin
      bits[nb++] = (e.data >> i) & 1;
      par ^= (e.data >> i) & 1;
    end
    if (e.mode == 1) bits[nb++] = par;
    if (e.mode == 2) bits[nb++] = par ^ 1;
    bits[nb++] = 1;
    if (e.two != 0) bits[nb++] = 1;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < e.div; c++) begin
        check($sformatf("d%02x_bit%0d_clk%0d", e.data, b, c), txs(sel), bits[b]);
        tick;
      end
  endtask

  initial begin
    tick; tick;
    check("rst_tx", tx8, 1);
    check("rst_busy", busy8, 0);
    check("rst_ready", s_ready8, 1);
    check("rst_level", level8, 0);
    check("rst_tx7", tx7, 1);
    rst_n = 1'b1;
    tick;
    // 8N1 div 4, one-cycle latency to start bit
    push(0, 8'hA5, 1, 4, 0, 0);
    check("lat_tx", tx8, 1);
    check("busy_on", busy8, 1);
    tick;
    recv(0, 1);
    check("busy_off_8n1", busy8, 0);
    // parity even and odd
    baud_div = 16'd2; parity_mode = 2'd1;
    push(0, 8'h07, 1, 2, 1, 0); tick; recv(0, 1);
    parity_mode = 2'd2;
    push(0, 8'h07, 1, 2, 2, 0); tick; recv(0, 1);
    check("busy_off_par", busy8, 0);
    // fill FIFO while first frame runs; sixth word dropped, rest sent back-to-back
    baud_div = 16'd4; parity_mode = 2'd0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(0, 8'h30 + i, i < 5, 4, 0, 0);
        check("full_level", level8, 4);
      end
      begin
        recv(0, 0);
        for (int i = 0; i < 4; i++) recv(0, 1);
      end
    join
    check("fill_busy_off", busy8, 0);
    check("fill_sb_empty", q.size(), 0);
    // divisor 0 behaves as 1
    baud_div = 16'd0;
    push(0, 8'h3C, 1, 0, 0, 0); tick; recv(0, 1);
    // divisor change mid-frame applies to the next frame only
    baud_div = 16'd4;
    push(0, 8'h11, 1, 4, 0, 0);
    push(0, 8'h22, 1, 2, 0, 0);
    fork
      begin repeat (10) tick; baud_div = 16'd2; end
      begin recv(0, 0); recv(0, 1); end
    join
    check("div_busy_off", busy8, 0);
    // 7-bit, two stop bits, div 3: 30-clock frame
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b1;
    push(1, 8'h41, 1, 3, 0, 1); tick; recv(1, 1);
    check("busy7_off", busy7, 0);
    check("level7", level7, 0);
    // reset during DATA aborts frame and empties FIFO
    baud_div = 16'd4; two_stop = 1'b0;
    push(0, 8'h00, 1, 4, 0, 0);
    push(0, 8'hFF, 1, 4, 0, 0);
    repeat (12) tick;
    rst_n = 1'b0;
    tick;
    check("mid_rst_tx", tx8, 1);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_level", level8, 0);
    rst_n = 1'b1;
    q.delete();
    tick;
    check("post_rst_tx", tx8, 1);
    push(0, 8'h5A, 1, 4, 0, 0); tick; recv(0, 1);
    check("post_rst_busy", busy8, 0);
    check("end_sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
